// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, run-time frame format latched per frame,
// received word and error flags held on a valid/ready handshake with overrun detection.
`timescale 1ns/1ps
module uart_rx #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 rx_i,
    input  logic                 cfg_parity_en_i,
    input  logic                 cfg_parity_type_i,
    input  logic [3:0]           cfg_num_data_bits_i,
    input  logic [1:0]           cfg_num_stop_bits_i,
    input  logic [DIV_WIDTH-1:0] cfg_clk_div_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_reg;
    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [3:0]           bit_cnt_reg;
    logic [3:0]           nbits_reg;
    logic [1:0]           nstop_reg;
    logic                 par_en_reg;
    logic                 par_type_reg;
    logic [7:0]           shift_reg;
    logic                 perr_pend_reg;
    logic                 ferr_pend_reg;

    logic [3:0]           nbits_clamp;
    logic [1:0]           nstop_clamp;
    logic [DIV_WIDTH-1:0] div_clamp;
    logic                 tick;
    logic                 last_stop;
    logic                 ferr_now;
    logic                 frame_done;
    logic [7:0]           data_final;

    assign nbits_clamp = (cfg_num_data_bits_i < 4'd5) ? 4'd5 :
                         (cfg_num_data_bits_i > 4'd8) ? 4'd8 : cfg_num_data_bits_i;
    assign nstop_clamp = (cfg_num_stop_bits_i == 2'd0) ? 2'd1 :
                         (cfg_num_stop_bits_i == 2'd3) ? 2'd2 : cfg_num_stop_bits_i;
    assign div_clamp   = (cfg_clk_div_i < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_clk_div_i;

    // The counter counts down to 1, so a load of L samples exactly L edges later.
    assign tick       = (cnt_reg == DIV_WIDTH'(1));
    assign last_stop  = (bit_cnt_reg == ({2'b00, nstop_reg} - 4'd1));
    assign ferr_now   = ferr_pend_reg | ~rx_s_reg;
    assign frame_done = (state_reg == STOP) && tick && last_stop;
    // Bits enter at the top, so a short word sits in the upper bits until aligned here.
    assign data_final = shift_reg >> (4'd8 - nbits_reg);
    assign busy_o     = (state_reg != IDLE);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_reg     <= IDLE;
            rx_meta_reg   <= 1'b1;
            rx_s_reg      <= 1'b1;
            cnt_reg       <= '0;
            div_reg       <= '0;
            bit_cnt_reg   <= '0;
            nbits_reg     <= '0;
            nstop_reg     <= '0;
            par_en_reg    <= 1'b0;
            par_type_reg  <= 1'b0;
            shift_reg     <= '0;
            perr_pend_reg <= 1'b0;
            ferr_pend_reg <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            parity_err_o  <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            rx_meta_reg <= rx_i;
            rx_s_reg    <= rx_meta_reg;
            overrun_o   <= 1'b0;

            if (frame_done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o    <= data_final;
                    parity_err_o <= perr_pend_reg;
                    frame_err_o  <= ferr_now;
                    rx_valid_o   <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        cnt_reg       <= div_clamp >> 1;
                        div_reg       <= div_clamp;
                        nbits_reg     <= nbits_clamp;
                        nstop_reg     <= nstop_clamp;
                        par_en_reg    <= cfg_parity_en_i;
                        par_type_reg  <= cfg_parity_type_i;
                        shift_reg     <= '0;
                        bit_cnt_reg   <= '0;
                        perr_pend_reg <= 1'b0;
                        ferr_pend_reg <= 1'b0;
                        state_reg     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_s_reg) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg   <= div_reg;
                            state_reg <= DATA;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_reg   <= div_reg;
                        shift_reg <= {rx_s_reg, shift_reg[7:1]};
                        if (bit_cnt_reg == nbits_reg - 4'd1) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= par_en_reg ? PARITY : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (tick) begin
                        cnt_reg   <= div_reg;
                        // Unused shift positions are zero, so the reduction covers only data bits.
                        if (rx_s_reg != ((^shift_reg) ^ par_type_reg)) begin
                            perr_pend_reg <= 1'b1;
                        end
                        state_reg <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg - DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_reg       <= div_reg;
                        ferr_pend_reg <= ferr_now;
                        if (last_stop) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= IDLE;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - DIV_WIDTH'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames with literal expectations plus randomized frames,
// all checked every cycle against a frame-level model of completions and busy windows.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DW = 16;

    logic          clk;
    logic          arst_ni;
    logic          rx_i;
    logic          cfg_par_en;
    logic          cfg_par_type;
    logic [3:0]    cfg_nbits;
    logic [1:0]    cfg_nstop;
    logic [DW-1:0] cfg_div;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    typedef struct { int c; logic [7:0] d; logic pe; logic fe; } word_t;
    typedef struct { int lo; int hi; } span_t;

    word_t exp_q[$];
    span_t busy_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    g_f = 0;
    int    ov_total = 0;
    int    rdy_mode = 0;
    logic  m_valid, m_pe, m_fe, m_ov, m_busy, cmp_rdy;
    logic [7:0] m_data;

    uart_rx #(.DIV_WIDTH(DW)) dut (
        .clk_i(clk), .arst_ni(arst_ni), .rx_i(rx_i),
        .cfg_parity_en_i(cfg_par_en), .cfg_parity_type_i(cfg_par_type),
        .cfg_num_data_bits_i(cfg_nbits), .cfg_num_stop_bits_i(cfg_nstop),
        .cfg_clk_div_i(cfg_div), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .rx_ready_i(rx_ready), .parity_err_o(parity_err), .frame_err_o(frame_err),
        .overrun_o(overrun), .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level model: deliveries happen at predicted completion cycles.
    always @(posedge clk) begin
        cmp_rdy = rx_ready;
        cyc = cyc + 1;
        #1;
        if (!arst_ni) begin
            m_valid = 0; m_data = 0; m_pe = 0; m_fe = 0; m_ov = 0;
        end else begin
            m_ov = 0;
            if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                if (!m_valid || cmp_rdy) begin
                    m_valid = 1; m_data = exp_q[0].d; m_pe = exp_q[0].pe; m_fe = exp_q[0].fe;
                end else begin
                    m_ov = 1;
                end
                void'(exp_q.pop_front());
            end else if (m_valid && cmp_rdy) begin
                m_valid = 0;
            end
        end
        while (busy_q.size() > 0 && busy_q[0].hi <= cyc) void'(busy_q.pop_front());
        m_busy = 0;
        foreach (busy_q[i]) if (busy_q[i].lo <= cyc && cyc < busy_q[i].hi) m_busy = 1;
        if (!arst_ni) m_busy = 0;
        chk("valid", rx_valid, m_valid);
        chk("data", rx_data, m_data);
        chk("parity_err", parity_err, m_pe);
        chk("frame_err", frame_err, m_fe);
        chk("overrun", overrun, m_ov);
        chk("busy", busy, m_busy);
    end

    always @(negedge clk) begin
        if (rdy_mode == 2) rx_ready = 1'($urandom_range(0, 1));
        else rx_ready = (rdy_mode == 1);
    end

    always @(posedge clk) begin
        #2;
        if (overrun === 1'b1) ov_total++;
    end

    task automatic send_frame(input logic [7:0] data, input int n_raw, input int s_raw,
                              input int div_raw, input logic pen, input logic ptype,
                              input logic bad_par, input logic bad_stop1,
                              input logic last_stop0, input logic scramble, input int abort_bit);
        int n, s, dv, h, nb, c_done;
        logic bits[12];
        logic [7:0] d, mask;
        logic pe, fe;
        n  = (n_raw < 5) ? 5 : (n_raw > 8) ? 8 : n_raw;
        s  = (s_raw == 0) ? 1 : (s_raw == 3) ? 2 : s_raw;
        dv = (div_raw < 4) ? 4 : div_raw;
        h  = dv / 2;
        mask = 8'hFF;
        mask = mask >> (8 - n);
        d = data & mask;
        bits[0] = 1'b0;
        for (int k = 0; k < n; k++) bits[1 + k] = d[k];
        nb = 1 + n;
        pe = 1'b0;
        if (pen) begin
            bits[nb] = (^d) ^ ptype ^ bad_par;
            pe = bad_par;
            nb++;
        end
        for (int k = 0; k < s; k++) bits[nb + k] = 1'b1;
        if (s == 2 && bad_stop1) bits[nb] = 1'b0;
        if (last_stop0) bits[nb + s - 1] = 1'b0;
        fe = 1'b0;
        for (int k = 0; k < s; k++) if (!bits[nb + k]) fe = 1'b1;
        nb += s;

        @(negedge clk);
        cfg_nbits = 4'(n_raw); cfg_nstop = 2'(s_raw); cfg_div = DW'(div_raw);
        cfg_par_en = pen; cfg_par_type = ptype;
        rx_i = 1'b0;
        g_f = cyc + 1;
        // Start seen 2 edges after the fall, sampled mid-bit, completes at the last sample.
        c_done = g_f + 2 + h + (nb - 1) * dv;
        exp_q.push_back('{c_done, d, pe, fe});
        busy_q.push_back('{g_f + 2, c_done});
        // A low final stop bit looks like a new start that is rejected half a bit later.
        if (last_stop0) busy_q.push_back('{c_done + 1, c_done + 1 + h});
        for (int j = 0; j < nb; j++) begin
            for (int c = 0; c < dv; c++) begin
                if (j != 0 || c != 0) @(negedge clk);
                if (c == 0) rx_i = bits[j];
                if (scramble && j == 0 && c == 3) begin
                    cfg_nbits = 4'($urandom); cfg_nstop = 2'($urandom);
                    cfg_div = DW'($urandom_range(0, 30));
                    cfg_par_en = 1'($urandom); cfg_par_type = 1'($urandom);
                end
                if (j == abort_bit && c == dv / 2) begin
                    arst_ni = 1'b0;
                    rx_i = 1'b1;
                    exp_q.delete();
                    busy_q.delete();
                    return;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_i = 1'b1;
        end
    endtask

    task automatic wait_valid(input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #2;
            if (rx_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("valid_timeout", rx_valid, 1);
    endtask

    initial begin
        int t, ov0;
        logic saw_busy, saw_valid;
        arst_ni = 1'b0; rx_i = 1'b1; rx_ready = 1'b0;
        cfg_par_en = 0; cfg_par_type = 0; cfg_nbits = 8; cfg_nstop = 1; cfg_div = 16;
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        arst_ni = 1'b1;
        rdy_mode = 1;
        idle(5);

        // 8N1 0xA5, latency from the falling edge
        fork
            send_frame(8'hA5, 8, 1, 16, 0, 0, 0, 0, 0, 0, -1);
            wait_valid(400, t);
        join
        chk("lat_8n1", t - g_f, 154);
        chk("data_a5", rx_data, 8'hA5);
        chk("a5_perr", parity_err, 0);
        chk("a5_ferr", frame_err, 0);
        idle(10);

        // 7E1 0x35 with a wrong parity bit, then 7O1 with a correct one
        fork
            send_frame(8'h35, 7, 1, 16, 1, 0, 1, 0, 0, 0, -1);
            wait_valid(400, t);
        join
        chk("data_35e", rx_data, 8'h35);
        chk("perr_even", parity_err, 1);
        idle(10);
        fork
            send_frame(8'h35, 7, 1, 16, 1, 1, 0, 0, 0, 0, -1);
            wait_valid(400, t);
        join
        chk("data_35o", rx_data, 8'h35);
        chk("perr_odd", parity_err, 0);
        idle(10);

        // 8N2 with second stop bit low
        fork
            send_frame(8'h3C, 8, 2, 16, 0, 0, 0, 0, 1, 0, -1);
            wait_valid(400, t);
        join
        chk("data_3c", rx_data, 8'h3C);
        chk("ferr_stop2", frame_err, 1);
        idle(40);

        // 4-cycle glitch is a false start
        @(negedge clk);
        cfg_div = 16; rx_i = 1'b0;
        g_f = cyc + 1;
        busy_q.push_back('{g_f + 2, g_f + 2 + 8});
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        saw_busy = 0; saw_valid = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            saw_busy |= busy;
            saw_valid |= rx_valid;
        end
        chk("glitch_busy_seen", saw_busy, 1);
        chk("glitch_no_valid", saw_valid, 0);
        chk("glitch_idle", busy, 0);

        // Overrun: two frames with the consumer stalled
        rdy_mode = 0;
        idle(4);
        ov0 = ov_total;
        send_frame(8'h11, 8, 1, 16, 0, 0, 0, 0, 0, 0, -1);
        send_frame(8'h22, 8, 1, 16, 0, 0, 0, 0, 0, 0, -1);
        idle(20);
        chk("overrun_count", ov_total - ov0, 1);
        chk("overrun_data", rx_data, 8'h11);
        chk("overrun_held", rx_valid, 1);
        rdy_mode = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("ready_drop", rx_valid, 0);
        idle(10);

        // Reset during data bit 3, then a clean frame
        send_frame(8'h77, 8, 1, 16, 0, 0, 0, 0, 0, 0, 4);
        repeat (4) @(negedge clk);
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_data", rx_data, 0);
        chk("midrst_busy", busy, 0);
        arst_ni = 1'b1;
        idle(20);
        fork
            send_frame(8'h5A, 8, 1, 16, 0, 0, 0, 0, 0, 0, -1);
            wait_valid(400, t);
        join
        chk("post_rst_data", rx_data, 8'h5A);
        idle(10);

        // Randomized frames, formats, gaps and consumer stalls
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int s_raw, dv_raw;
            s_raw  = $urandom_range(0, 3);
            dv_raw = $urandom_range(0, 24);
            send_frame(8'($urandom), $urandom_range(0, 15), s_raw, dv_raw,
                       1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) == 0), 1'b0, 1'($urandom), -1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 40));
        end
        rdy_mode = 1;
        idle(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Configurable UART receiver: the serial-to-parallel counterpart of the AXI2UART transmit path. It deserializes frames from the UART line according to the run-time frame configuration (data bits, parity enable/type, stop bits, baud divisor) and presents each byte with error flags on a valid/ready handshake. It sits between the `uart_rx` pad and the AXI-side receive buffer, and also serves as the line checker in the verification environment.

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the clocks-per-bit divisor.

Ports:
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `arst_ni`  in  1  asynchronous active-low reset.
- `rx_i`  in  1  serial line, idle high, asynchronous to `clk_i`.
- `cfg_parity_en_i`  in  1  1 = parity bit present.
- `cfg_parity_type_i`  in  1  0 = even, 1 = odd.
- `cfg_num_data_bits_i`  in  4  data bits per frame, legal 5..8.
- `cfg_num_stop_bits_i`  in  2  stop bits, legal 1..2.
- `cfg_clk_div_i`  in  DIV_WIDTH  `clk_i` cycles per bit.
- `rx_data_o`  out  8  received data, LSB first on the line, zero-extended.
- `rx_valid_o`  out  1  `rx_data_o` and flags are valid.
- `rx_ready_i`  in  1  consumer accepts the current word.
- `parity_err_o`  out  1  parity mismatch for the current word.
- `frame_err_o`  out  1  a stop bit was sampled low for the current word.
- `overrun_o`  out  1  one-cycle pulse: a frame completed while the output was still full.
- `busy_o`  out  1  a frame is in progress (state != IDLE).

## Operation
- `rx_i` passes through a 2-flop synchronizer; all decisions use the synchronized value `rx_s`.
- Configuration is latched on leaving IDLE and held for the whole frame. Mid-frame config changes take effect on the next frame.
- Clamping: `num_data_bits` < 5 is treated as 5 and > 8 as 8. `num_stop_bits` of 0 is treated as 1 and 3 as 2. `clk_div` < 4 is treated as 4.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on `rx_s` = 0, load the bit counter with `clk_div/2` (floor) and go to START.
  - START: at counter expiry, sample `rx_s`. If 1, it is a false start: return to IDLE with no output. Otherwise reload `clk_div` and go to DATA.
  - DATA: sample one bit per `clk_div` cycles into the shift register, LSB first. After `num_data_bits` samples, go to PARITY if enabled, else to STOP.
  - PARITY: sample one bit. Expected bit is the XOR of the data bits (even), inverted for odd. A mismatch sets the pending parity error.
  - STOP: sample `num_stop_bits` bits, one per `clk_div`. Any 0 sets the pending frame error. After the last stop sample, complete the frame and go to IDLE in the same cycle.
- Frame completion:
  - If `rx_valid_o` = 0, or `rx_valid_o` = 1 with `rx_ready_i` = 1 in that cycle: load `rx_data_o`, `parity_err_o`, `frame_err_o` and set `rx_valid_o`.
  - Otherwise the new frame is discarded, the held word and flags are unchanged, and `overrun_o` pulses for one cycle.
- Frames with errors are still delivered, with their flags set.
- Handshake: `rx_valid_o` stays high until a cycle with `rx_ready_i` = 1. It then clears on the next edge unless a frame completes in that same cycle. Data and flags are stable while valid.
- Unused upper bits of `rx_data_o` are 0.

## Timing
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, counters 0, synchronizer flops reset to 1 (idle line).
- Reset mid-frame aborts the frame; no partial word is delivered.
- Let E be the first edge at which `rx_s` = 0 (2 cycles after `rx_i` falls).
  - Start sample at E + `clk_div/2`.
  - Bit k (k = 0..n-1) sampled at E + `clk_div/2` + (k+1)·`clk_div`.
  - The parity sample and each stop sample follow every `clk_div` cycles.
- `rx_valid_o` rises on the edge following the last stop sample. IDLE is re-entered at the same time, so a back-to-back start bit is detected at its next low sample with no dead cycle.
- Throughput: one frame per (1 + n + parity + stop)·`clk_div` cycles sustained, with `rx_ready_i` held high.

## Test plan
- 8N1, `clk_div` = 16, send 0xA5 → `rx_data_o` = 0xA5, `rx_valid_o` rises 2 + 8 + 9·16 cycles after the falling edge, both error flags 0.
- 7 data bits, even parity, 1 stop, send 0x35 with parity bit 1 (wrong) → `rx_data_o` = 0x35, `parity_err_o` = 1. Repeat with odd parity and bit 1 → `parity_err_o` = 0.
- 8N2, first stop bit 1, second stop bit 0, send 0x3C → `rx_data_o` = 0x3C, `frame_err_o` = 1.
- Low glitch of 4 cycles on `rx_i`, `clk_div` = 16 → `busy_o` pulses, returns to 0, `rx_valid_o` never asserts.
- Two 8N1 frames 0x11 then 0x22 with `rx_ready_i` = 0 → `overrun_o` pulses once and `rx_data_o` stays 0x11. Raise `rx_ready_i` → `rx_valid_o` drops on the next edge.
- Assert `arst_ni` during bit 3 of a frame, then release and send 0x5A → all outputs 0 during reset, no partial word, next frame received as 0x5A.
